// File: rtl/esc_pwm_capture_if.sv
// esc_pwm_capture_if: PWM input, offset and decoded-speed outputs of the ESC PWM capture block
interface esc_pwm_capture_if;
  logic        PWM_in;
  logic [9:0]  OFF;
  logic [10:0] SPEED;
  logic        vld;
  logic        err;
  logic        timeout;
  modport master(output PWM_in, OFF, input SPEED, vld, err, timeout);
  modport slave(input PWM_in, OFF, output SPEED, vld, err, timeout);
endinterface

// File: rtl/esc_pwm_capture.sv
// esc_pwm_capture: measures PWM width/period and recovers the encoded 11-bit speed command
module esc_pwm_capture #(
  parameter int PULSE_OFFSET = 50000,
  parameter int PER_MIN      = 1000000,
  parameter int PER_MAX      = 1100000,
  parameter int CNT_W        = 21,
  parameter int CODE_SHIFT   = 4
) (
  input logic               clk,
  input logic               rst,
  esc_pwm_capture_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam int W_HI_I = PULSE_OFFSET + (3070 << CODE_SHIFT) + (1 << CODE_SHIFT) - 1;
  localparam logic [16:0]      W_LO  = 17'(PULSE_OFFSET);
  localparam logic [16:0]      W_HI  = 17'(W_HI_I);
  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(PER_MIN);
  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(PER_MAX);
  state_t             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [16:0]        wcnt_q, wcnt_d, wlat_q, wlat_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [10:0]        speed_q, speed_d;
  logic               vld_q, vld_d, err_q, err_d, to_q, to_d;
  logic               rise, fall, tmo, reject;
  logic [11:0]        code;
  logic signed [12:0] diff;
  logic [10:0]        spd;
  always_comb begin
    sync_d = {sync_q[1:0], bus.PWM_in};
    rise   = sync_q[1] & ~sync_q[2];
    fall   = ~sync_q[1] & sync_q[2];
    tmo    = pcnt_q >= P_MAX;
    wcnt_d = rise ? 17'd1 : (state_q == HIGH && ~&wcnt_q) ? wcnt_q + 17'd1 : wcnt_q;
    pcnt_d = rise ? CNT_W'(1) : &pcnt_q ? pcnt_q : pcnt_q + CNT_W'(1);
    reject = pcnt_q < P_MIN || wlat_q < W_LO || wlat_q > W_HI;
    code   = 12'((wlat_q - W_LO) >> CODE_SHIFT);
    diff   = $signed({1'b0, code}) - $signed({3'b0, bus.OFF});
    spd    = diff[12] ? 11'd0 : diff[11] ? 11'h7ff : diff[10:0];
  end
  always_comb begin
    state_d = state_q;
    wlat_d  = wlat_q;
    speed_d = speed_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
        else if (tmo) begin
          to_d    = 1'b1;
          speed_d = '0;
        end
      end
      HIGH: begin
        if (tmo) begin
          to_d    = 1'b1;
          speed_d = '0;
          state_d = IDLE;
        end else if (fall) begin
          wlat_d  = wcnt_q;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          err_d   = reject;
          vld_d   = ~reject;
          speed_d = reject ? speed_q : spd;
          to_d    = reject ? to_q : 1'b0;
        end else if (tmo) begin
          to_d    = 1'b1;
          speed_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      wcnt_q  <= '0;
      wlat_q  <= '0;
      pcnt_q  <= '0;
      speed_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      wcnt_q  <= wcnt_d;
      wlat_q  <= wlat_d;
      pcnt_q  <= pcnt_d;
      speed_q <= speed_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end
  assign bus.SPEED   = speed_q;
  assign bus.vld     = vld_q;
  assign bus.err     = err_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_esc_pwm_capture.sv
// tb_esc_pwm_capture: frame-level reference model feeding a scoreboard checked by an output monitor
module tb_esc_pwm_capture;
  localparam int PO = 40, PMIN = 3150, PMAX = 3300, SH = 0;
  typedef struct packed {logic [1:0] k; logic [10:0] s;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  bit armed = 0;
  int pw = 0, pp = 0;
  logic [10:0] last_spd = '0;
  esc_pwm_capture_if bus();
  esc_pwm_capture #(.PULSE_OFFSET(PO), .PER_MIN(PMIN), .PER_MAX(PMAX), .CNT_W(12), .CODE_SHIFT(SH))
    dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string n, int a, int e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(exp_t e);
    sb.push_back(e);
    last_spd = e.s;
  endtask
  function automatic exp_t eval(int w, int p, int off);
    exp_t e;
    int s;
    if (p < PMIN || w < PO || w > PO + (3070 << SH) + (1 << SH) - 1) begin
      e.k = 2'd1;
      e.s = last_spd;
    end else begin
      s = ((w - PO) >> SH) - off;
      s = s < 0 ? 0 : s > 2047 ? 2047 : s;
      e.k = 2'd0;
      e.s = 11'(s);
    end
    return e;
  endfunction
  task automatic frame(int w, int p, int off);
    bus.OFF = 10'(off);
    if (armed) push(eval(pw, pp, off));
    armed = 1;
    pw = w;
    pp = p;
    if (w > PMAX) begin
      push('{2'd2, 11'd0});
      armed = 0;
    end
    bus.PWM_in = 1'b1;
    tick(w);
    bus.PWM_in = 1'b0;
    tick(p - w);
  endtask
  task automatic idle(int n);
    if (armed && pp + n > PMAX) begin
      push('{2'd2, 11'd0});
      armed = 0;
    end else pp += n;
    tick(n);
  endtask
  task automatic reset_frame(int w, int p, int off);
    bus.OFF = 10'(off);
    if (armed) push(eval(pw, pp, off));
    bus.PWM_in = 1'b1;
    tick(200);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_speed", int'(bus.SPEED), 0);
    check("rst_vld", int'(bus.vld), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    last_spd = '0;
    armed = 1;
    pw = 0;
    pp = 0;
    tick(w - 201);
    bus.PWM_in = 1'b0;
    tick(p - w);
  endtask
  initial begin
    logic to_prev;
    exp_t e;
    int k;
    to_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.vld || bus.err || (bus.timeout && !to_prev))) begin
        k = bus.vld ? 0 : bus.err ? 1 : 2;
        check("vld_err_excl", int'(bus.vld && bus.err), 0);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d speed %0d expected none", k, bus.SPEED);
        end else begin
          e = sb.pop_front();
          check("event_kind", k, int'(e.k));
          check("speed", int'(bus.SPEED), int'(e.s));
          if (k == 0) check("timeout_clr", int'(bus.timeout), 0);
        end
      end
      to_prev = bus.timeout;
    end
  end
  initial begin
    #1_200_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.PWM_in = 1'b0;
    bus.OFF = '0;
    tick(3);
    rst = 1'b0;
    check("init_speed", int'(bus.SPEED), 0);
    check("init_vld", int'(bus.vld), 0);
    check("init_err", int'(bus.err), 0);
    check("init_timeout", int'(bus.timeout), 0);
    frame(340, 3200, 0);
    frame(340, 3200, 0);
    frame(340, 3200, 100);
    frame(90, 3200, 100);
    frame(3110, 3200, 100);
    frame(3111, 3200, 0);
    frame(39, 3200, 0);
    frame(500, 3149, 0);
    frame(500, 3200, 0);
    frame(600, 3150, 0);
    frame(700, 3200, 7);
    idle(200);
    frame(800, 3200, 0);
    frame(300, 3200, 0);
    frame(3350, 3400, 0);
    frame(400, 3200, 5);
    reset_frame(1000, 3200, 0);
    frame(450, 3200, 0);
    frame(450, 3200, 3);
    for (int i = 0; i < 3; i++)
      frame(int'($urandom_range(3120, 30)), int'($urandom_range(3290, 3130)), int'($urandom_range(1023, 0)));
    frame(100, 3200, 0);
    tick(20);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/esc_pwm_capture.md
Name: esc_pwm_capture

Overview:
- Receive-side decoder for the ESC PWM link. It captures an incoming PWM waveform, measures high-pulse width and period, and recovers the 11-bit SPEED command the transmitter encoded.
- Encoding recovered: high width W clocks = PULSE_OFFSET + 16*(SPEED+OFF) + r, where 0 <= r <= 15.
- Used on the bench/loopback side and by the ESC-emulation model to close the loop on the PWM generator.

Parameters:
PULSE_OFFSET  50000    constant high-time offset in clocks
PER_MIN       1000000  minimum legal rising-to-rising period in clocks
PER_MAX       1100000  maximum legal period; reaching it without a rising edge is a timeout
CNT_W         21       width of the period counter; must hold PER_MAX

Ports:
clk      in   1   system clock
rst      in   1   synchronous, active-high reset
PWM_in   in   1   asynchronous PWM input
OFF      in   10  per-motor offset subtracted from the recovered code
SPEED    out  11  last recovered speed
vld      out  1   one-cycle pulse when SPEED is updated
err      out  1   one-cycle pulse when a completed frame is rejected
timeout  out  1   level; no valid edge within PER_MAX cycles

Behaviour:
- Reset (rst sampled high at posedge clk):
  - SPEED=0, vld=0, err=0, timeout=0.
  - Synchronizer flops 0; counters 0; state IDLE.
  - rst has priority over every other event.
- Input conditioning:
  - PWM_in passes through a 2-flop synchronizer, then one more flop for edge detect.
  - rise = s & ~s_d; fall = ~s & s_d. All timing is measured on the synchronized signal.
- Width counter (17 b) and period counter (CNT_W b):
  - Both clear to 1 on rise and saturate at all-ones.
  - Width counts while in HIGH. Period counts in all states.
- FSM:
  - IDLE: ignores fall. On rise, go to HIGH.
  - HIGH: on fall, latch width W and go to LOW. If the period counter reaches PER_MAX, go to IDLE via the timeout action.
  - LOW: on rise, evaluate the frame (below), restart counters, go to HIGH. If the period counter reaches PER_MAX, take the timeout action.
  - Timeout action: assert timeout and set SPEED=0 (fail-safe). The state then goes to IDLE, or stays there.
  - timeout remains high until the next vld.
  - Timeout also applies in IDLE, with the period counter running since reset or the last rise.
- Frame evaluation (on the rise that closes a frame in LOW):
  - P = period count at that rise.
  - Reject if P < PER_MIN, W < PULSE_OFFSET, or W > PULSE_OFFSET + 16*3070 + 15 (= 99135 at default).
  - On reject: err pulses 1 cycle and SPEED is held.
  - Otherwise: code = (W - PULSE_OFFSET) >> 4 (12 b). spd = code - OFF, computed signed 13 b and clamped to [0, 2047].
  - SPEED registers spd and vld pulses on the same cycle SPEED changes.
  - vld and err are mutually exclusive.
- Latency:
  - SPEED/vld are registered 1 clk after rise is detected.
  - rise is detected 3 clks after PWM_in goes high.
- Boundaries:
  - A pulse still high at PER_MAX causes a timeout, not a frame.
  - The first rise after reset or timeout only starts a frame; it produces no vld or err.
  - A reset mid-pulse discards the partial frame.
  - OFF is sampled at the evaluation cycle only.

Test Plan:
- OFF=0; high 54800 clks (code 300), period 1048576 -> vld once per period with SPEED=300; err=0, timeout=0.
- OFF=100, same waveform -> SPEED=200. Then high 50000+16*50 with OFF=100 -> SPEED=0 (clamp), vld=1.
- OFF=0, high 99135 -> SPEED=2047 (clamp), vld=1. High 99136 -> err pulse, SPEED keeps 2047.
- High 49999 -> err, no vld. Period 900000 with legal width -> err, SPEED unchanged.
- After valid frames, hold PWM_in low 1100010 clks -> timeout=1 and SPEED=0 when the counter hits PER_MAX. The next complete legal frame -> vld, timeout=0.
- Assert rst for 1 clk mid-high-pulse -> all outputs 0, state IDLE. The first following rise yields no vld; the frame after it decodes normally.
